// File: rtl/prio_enc_rr_pipe_if.sv
// Handshake bundle for prio_enc_rr_pipe: request side (in_*, req, mode) and
// grant side (out_*). The arbiter is the slave; the producer/consumer pair is the master.
interface prio_enc_rr_pipe_if #(
  parameter int N = 64
) ();
  localparam int IDX_W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     req;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_found;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;

  modport master (
    output in_valid, req, mode, out_ready,
    input  in_ready, out_valid, out_found, out_idx, out_onehot
  );

  modport slave (
    input  in_valid, req, mode, out_ready,
    output in_ready, out_valid, out_found, out_idx, out_onehot
  );
endinterface

// File: rtl/prio_enc_rr_pipe.sv
// Two-stage pipelined N-input priority encoder / arbiter with per-transaction
// fixed (lowest index) or round-robin priority and valid/ready flow control.
module prio_enc_rr_pipe #(
  parameter  int N     = 64,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_enc_rr_pipe_if.slave bus
);

  logic             r_s1_v;
  logic [N-1:0]     r_s1_req;
  logic             r_s1_mode;

  logic             r_s2_v;
  logic             r_found;
  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]     r_onehot;
  logic [IDX_W-1:0] r_ptr;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [N-1:0]     w_rr_mask;
  logic [N-1:0]     w_masked;
  logic [N-1:0]     w_sel;
  logic [N-1:0]     w_onehot;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ptr_nxt;

  assign w_s2_adv = !r_s2_v || bus.out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      r_s1_v    <= 1'b0;
      r_s1_req  <= '0;
      r_s1_mode <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_req  <= bus.req;
        r_s1_mode <= bus.mode;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational signal unassigned (no latch).
    w_rr_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_rr_mask[i] = (IDX_W'(i) >= r_ptr);
    end
  end

  // Round-robin searches from ptr upward; if nothing at or above ptr, wrap to the full vector.
  assign w_masked = r_s1_req & w_rr_mask;
  assign w_sel    = (r_s1_mode && (|w_masked)) ? w_masked : r_s1_req;
  assign w_onehot = w_sel & (~w_sel + N'(1));
  assign w_found  = |r_s1_req;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_onehot[i]) begin
        w_idx = w_idx | IDX_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v   <= 1'b0;
      r_found  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_found  <= w_found;
        r_idx    <= w_idx;
        r_onehot <= w_onehot;
        if (r_s1_mode && w_found) begin
          r_ptr <= w_ptr_nxt;
        end
      end
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_s2_v;
  assign bus.out_found  = r_found;
  assign bus.out_idx    = r_idx;
  assign bus.out_onehot = r_onehot;

endmodule

// File: tb/tb_prio_enc_rr_pipe.sv
// Self-checking bench for prio_enc_rr_pipe (N=64 and N=10) against a
// queue-based reference model that walks the request vector from the pointer.
`timescale 1ns/1ps
module tb_prio_enc_rr_pipe;

  typedef struct {
    bit found;
    int idx;
    int ptr;
  } exp_t;

  typedef struct {
    logic        in_ready;
    logic        out_valid;
    logic        found;
    logic [31:0] idx;
    logic [63:0] onehot;
    logic [31:0] ptr;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_enc_rr_pipe_if #(.N(64)) bus64 ();
  prio_enc_rr_pipe_if #(.N(10)) bus10 ();

  prio_enc_rr_pipe #(.N(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
  prio_enc_rr_pipe #(.N(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q64[$];
  exp_t q10[$];
  int   mptr64 = 0;
  int   mptr10 = 0;

  // Reference: walk upward from the start point, wrapping, first set bit wins.
  function automatic exp_t ref_arb(input int n, input logic [63:0] r, input bit m, inout int ptr);
    exp_t e;
    int   start;
    int   j;
    e.found = 1'b0;
    e.idx   = 0;
    start   = m ? ptr : 0;
    for (int k = 0; k < n; k++) begin
      j = (start + k) % n;
      if (!e.found && r[j]) begin
        e.found = 1'b1;
        e.idx   = j;
      end
    end
    if (m && e.found) ptr = (e.idx + 1) % n;
    e.ptr = ptr;
    return e;
  endfunction

  function automatic logic [63:0] oh_of(input exp_t e);
    return e.found ? (64'd1 << e.idx) : 64'd0;
  endfunction

  function automatic logic [63:0] rand_req(input int n);
    logic [63:0] r;
    r = '0;
    case ($urandom_range(0, 3))
      0: r = '0;
      1: r[$urandom_range(0, n - 1)] = 1'b1;
      2: begin
        r[$urandom_range(0, n - 1)] = 1'b1;
        r[$urandom_range(0, n - 1)] = 1'b1;
      end
      default: r = {$urandom, $urandom} & ((64'd1 << n) - 64'd1);
    endcase
    return r;
  endfunction

  // Called at a falling edge: drive, sample, update the model, advance to the next falling edge.
  task automatic step64(input bit v, input logic [63:0] r, input bit m, input bit ordy,
                        output obs_t o, output bit er, output bit he, output exp_t e);
    exp_t ne;
    bus64.in_valid  = v;
    bus64.req       = r;
    bus64.mode      = m;
    bus64.out_ready = ordy;
    #1;
    o.in_ready  = bus64.in_ready;
    o.out_valid = bus64.out_valid;
    o.found     = bus64.out_found;
    o.idx       = 32'(bus64.out_idx);
    o.onehot    = bus64.out_onehot;
    o.ptr       = 32'(dut64.r_ptr);
    er = (q64.size() < 2) || ordy;
    he = (q64.size() > 0);
    e.found = 1'b0; e.idx = 0; e.ptr = 0;
    if (he) e = q64[0];
    if (o.out_valid === 1'b1 && ordy && he) void'(q64.pop_front());
    if (v && o.in_ready === 1'b1) begin
      ne = ref_arb(64, r, m, mptr64);
      q64.push_back(ne);
    end
    @(negedge clk);
  endtask

  task automatic step10(input bit v, input logic [63:0] r, input bit m, input bit ordy,
                        output obs_t o, output bit er, output bit he, output exp_t e);
    exp_t ne;
    bus10.in_valid  = v;
    bus10.req       = r[9:0];
    bus10.mode      = m;
    bus10.out_ready = ordy;
    #1;
    o.in_ready  = bus10.in_ready;
    o.out_valid = bus10.out_valid;
    o.found     = bus10.out_found;
    o.idx       = 32'(bus10.out_idx);
    o.onehot    = 64'(bus10.out_onehot);
    o.ptr       = 32'(dut10.r_ptr);
    er = (q10.size() < 2) || ordy;
    he = (q10.size() > 0);
    e.found = 1'b0; e.idx = 0; e.ptr = 0;
    if (he) e = q10[0];
    if (o.out_valid === 1'b1 && ordy && he) void'(q10.pop_front());
    if (v && o.in_ready === 1'b1) begin
      ne = ref_arb(10, r, m, mptr10);
      q10.push_back(ne);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus64.in_valid = 1'b0; bus64.req = '0; bus64.mode = 1'b0; bus64.out_ready = 1'b1;
    bus10.in_valid = 1'b0; bus10.req = '0; bus10.mode = 1'b0; bus10.out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus64.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus64.in_ready); end
    n_cmp++; if (bus64.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus64.out_valid); end
    n_cmp++; if (bus64.out_found !== 1'b0) begin n_bad++; $display("FAIL reset_found: got %b want 0", bus64.out_found); end
    n_cmp++; if (bus64.out_idx !== 6'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", bus64.out_idx); end
    n_cmp++; if (bus64.out_onehot !== 64'd0) begin n_bad++; $display("FAIL reset_onehot: got %h want 0", bus64.out_onehot); end
    n_cmp++; if (dut64.r_ptr !== 6'd0) begin n_bad++; $display("FAIL reset_ptr: got %0d want 0", dut64.r_ptr); end
    n_cmp++; if (bus10.out_valid !== 1'b0 || bus10.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_n10: got valid=%b ready=%b want 0/1", bus10.out_valid, bus10.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus64.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus64.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_fixed();
    obs_t o; exp_t e; bit er; bit he; logic ev;
    logic [63:0] a;
    a = (64'd1 << 5) | (64'd1 << 40);
    for (int s = 0; s < 4; s++) begin
      step64(s == 0, a, 1'b0, 1'b1, o, er, he, e);
      ev = (s == 2);
      n_cmp++; if (o.in_ready !== er) begin n_bad++; $display("FAIL fixed_in_ready s%0d: got %b want %b", s, o.in_ready, er); end
      n_cmp++; if (o.out_valid !== ev) begin n_bad++; $display("FAIL fixed_out_valid s%0d: got %b want %b", s, o.out_valid, ev); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL fixed_result s%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   s, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
      end
    end
  endtask

  // Back-to-back RR sequence, pointer wrap, then empty requests in both modes.
  task automatic test_back_to_back();
    obs_t o; exp_t e; bit er; bit he; logic ev;
    logic [63:0] a;
    logic [63:0] tr [7];
    bit          tm [7];
    int          k;
    a  = (64'd1 << 5) | (64'd1 << 40);
    tr = '{a, a, a, 64'd1 << 63, (64'd1 << 63) | 64'd1, 64'd0, 64'd0};
    tm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 10; s++) begin
      k = (s < 7) ? s : 0;
      step64(s < 7, tr[k], tm[k], 1'b1, o, er, he, e);
      ev = (s >= 2 && s <= 8);
      n_cmp++; if (o.in_ready !== er) begin n_bad++; $display("FAIL b2b_in_ready s%0d: got %b want %b", s, o.in_ready, er); end
      n_cmp++; if (o.out_valid !== ev) begin n_bad++; $display("FAIL b2b_out_valid s%0d: got %b want %b", s, o.out_valid, ev); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL b2b_result s%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   s, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e; bit er; bit he; logic ev;
    logic [63:0] vec [3];
    bit          vm [3];
    for (int i = 0; i < 3; i++) begin
      vec[i] = rand_req(64) | (64'd1 << $urandom_range(0, 63));
      vm[i]  = 1'($urandom_range(0, 1));
    end
    for (int s = 0; s < 10; s++) begin
      step64(s <= 6, vec[(s < 2) ? s : 2], vm[(s < 2) ? s : 2], s >= 6, o, er, he, e);
      ev = (s >= 2 && s <= 8);
      n_cmp++; if (o.in_ready !== er) begin n_bad++; $display("FAIL bp_in_ready s%0d: got %b want %b", s, o.in_ready, er); end
      n_cmp++; if (o.out_valid !== ev) begin n_bad++; $display("FAIL bp_out_valid s%0d: got %b want %b", s, o.out_valid, ev); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL bp_result s%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   s, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
      end
    end
    n_cmp++; if (q64.size() != 0) begin n_bad++; $display("FAIL bp_drain: got %0d results left want 0", q64.size()); end
  endtask

  task automatic test_reset_midflight();
    obs_t o; exp_t e; bit er; bit he; logic ev;
    logic [63:0] b;
    b = (64'd1 << 3) | (64'd1 << 30);
    step64(1'b1, 64'd1 << 20, 1'b1, 1'b0, o, er, he, e);
    step64(1'b1, b, 1'b1, 1'b0, o, er, he, e);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus64.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", bus64.out_valid); end
    n_cmp++; if (bus64.out_found !== 1'b0 || bus64.out_idx !== 6'd0 || bus64.out_onehot !== 64'd0) begin
      n_bad++; $display("FAIL midrst_outputs: got f=%b idx=%0d oh=%h want 0/0/0", bus64.out_found, bus64.out_idx, bus64.out_onehot);
    end
    n_cmp++; if (dut64.r_ptr !== 6'd0) begin n_bad++; $display("FAIL midrst_ptr: got %0d want 0", dut64.r_ptr); end
    n_cmp++; if (bus64.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", bus64.in_ready); end
    q64.delete(); q10.delete();
    mptr64 = 0; mptr10 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step64(s == 0, b, 1'b1, 1'b1, o, er, he, e);
      ev = (s == 2);
      n_cmp++; if (o.out_valid !== ev) begin n_bad++; $display("FAIL midrst_after_valid s%0d: got %b want %b", s, o.out_valid, ev); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL midrst_after_result s%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   s, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
        n_cmp++; if (o.idx !== 32'd3) begin n_bad++; $display("FAIL midrst_idx3: got %0d want 3", o.idx); end
      end
    end
  endtask

  task automatic test_random64();
    obs_t o; exp_t e; bit er; bit he;
    bit v; bit m; bit ordy;
    logic [63:0] r;
    int sent;
    int steps;
    sent = 0; steps = 0;
    while ((sent < 300 || q64.size() > 0) && steps < 4000) begin
      v    = (sent < 300) && ($urandom_range(0, 3) != 0);
      r    = rand_req(64);
      m    = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 9) < 7);
      step64(v, r, m, ordy, o, er, he, e);
      steps++;
      if (v && o.in_ready === 1'b1) sent++;
      n_cmp++; if (o.in_ready !== er) begin n_bad++; $display("FAIL rnd64_in_ready step%0d: got %b want %b", steps, o.in_ready, er); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL rnd64_result step%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   steps, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
      end
    end
    n_cmp++; if (steps >= 4000) begin n_bad++; $display("FAIL rnd64_timeout: got %0d sent, %0d pending want 300/0", sent, q64.size()); end
  endtask

  task automatic test_n10();
    obs_t o; exp_t e; bit er; bit he; logic ev;
    bit v; bit m; bit ordy;
    logic [63:0] r;
    int sent;
    int steps;
    for (int s = 0; s < 14; s++) begin
      step10(s < 11, 64'h3FF, 1'b1, 1'b1, o, er, he, e);
      ev = (s >= 2 && s <= 12);
      n_cmp++; if (o.out_valid !== ev) begin n_bad++; $display("FAIL n10_out_valid s%0d: got %b want %b", s, o.out_valid, ev); end
      n_cmp++; if (o.ptr > 32'd9) begin n_bad++; $display("FAIL n10_ptr_range s%0d: got %0d want <=9", s, o.ptr); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL n10_seq_result s%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   s, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
      end
    end
    sent = 0; steps = 0;
    while ((sent < 150 || q10.size() > 0) && steps < 2000) begin
      v    = (sent < 150) && ($urandom_range(0, 3) != 0);
      r    = rand_req(10);
      m    = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 9) < 7);
      step10(v, r, m, ordy, o, er, he, e);
      steps++;
      if (v && o.in_ready === 1'b1) sent++;
      n_cmp++; if (o.in_ready !== er) begin n_bad++; $display("FAIL rnd10_in_ready step%0d: got %b want %b", steps, o.in_ready, er); end
      if (o.out_valid === 1'b1) begin
        n_cmp++;
        if (!he || o.found !== e.found || o.idx !== e.idx || o.onehot !== oh_of(e) || o.ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL rnd10_result step%0d: got f=%b idx=%0d oh=%h ptr=%0d want f=%b idx=%0d oh=%h ptr=%0d q=%b",
                   steps, o.found, o.idx, o.onehot, o.ptr, e.found, e.idx, oh_of(e), e.ptr, he);
        end
      end
    end
    n_cmp++; if (steps >= 2000) begin n_bad++; $display("FAIL rnd10_timeout: got %0d sent, %0d pending want 150/0", sent, q10.size()); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random64();
    test_n10();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
